mem_arbiter: RTL and testbench

Two-port to one-port memory arbiter. It shares the single off-chip memory bus between the I-cache and D-cache refill/writeback ports, so that both caches can sit behind one slow memory. It sits between the two cache modules and the memory model, below the five-stage pipeline. The D-cache has fixed priority, with an anti-starvation limit that guarantees instruction fetch makes progress.

---
 rtl/mem_arbiter_pkg.sv | 25 ++
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_arbiter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared memory-bus definitions: default line address/data widths and the
//   arbiter FSM state encoding. The cache and memory models include the same
//   definitions, so the encoding here must stay in sync with them.
package mem_arbiter_pkg;

  // 128-bit lines; the word offset is stripped from the line address.
  localparam int MEM_ADDR_W = 28;
  localparam int MEM_DATA_W = 128;

  // Width of the D-grant streak counter.
  localparam int STREAK_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_e;

  // Saturating increment for the streak counter.
  function automatic logic [STREAK_W-1:0] sat_inc(input logic [STREAK_W-1:0] v);
    return (v == {STREAK_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one memory line bus between the I-cache and D-cache ports.
//   The D-cache has fixed priority, but after D_STREAK_MAX consecutive
//   D grants taken while the I-cache was waiting, the I-cache is served.
//
// Ports
//   clk, rst_n                    clock, synchronous active-low reset
//   I_mem_read/write/addr/wdata   I-cache request (held until I_mem_ready)
//   I_mem_rdata, I_mem_ready      read line and completion pulse to I-cache
//   D_mem_read/write/addr/wdata   D-cache request (held until D_mem_ready)
//   D_mem_rdata, D_mem_ready      read line and completion pulse to D-cache
//   mem_read/write/addr/wdata     registered request to memory
//   mem_rdata, mem_ready          memory read line and completion pulse
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = MEM_ADDR_W,
  parameter int DATA_W       = MEM_DATA_W,
  parameter int D_STREAK_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              I_mem_read,
  input  logic              I_mem_write,
  input  logic [ADDR_W-1:0] I_mem_addr,
  input  logic [DATA_W-1:0] I_mem_wdata,
  output logic [DATA_W-1:0] I_mem_rdata,
  output logic              I_mem_ready,

  input  logic              D_mem_read,
  input  logic              D_mem_write,
  input  logic [ADDR_W-1:0] D_mem_addr,
  input  logic [DATA_W-1:0] D_mem_wdata,
  output logic [DATA_W-1:0] D_mem_rdata,
  output logic              D_mem_ready,

  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(D_STREAK_MAX);

  arb_state_e          state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                read_q, read_d;
  logic                write_q, write_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic req_i, req_d, streak_hit, win_i, win_d;

  assign req_i      = I_mem_read | I_mem_write;
  assign req_d      = D_mem_read | D_mem_write;
  assign streak_hit = (streak_q == STREAK_LIMIT);

  // Arbitration decision, only acted upon in IDLE. The two wins are
  // mutually exclusive: D loses only when I is waiting at the streak limit.
  assign win_d = req_d & ~(req_i & streak_hit);
  assign win_i = req_i & (~req_d | streak_hit);

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      streak_q <= '0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      read_q   <= read_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (win_d)      state_d = GRANT_D;
        else if (win_i) state_d = GRANT_I;
      end
      GRANT_I, GRANT_D: begin
        if (mem_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Request capture and streak counter. The winner's command is latched on
  // the grant edge so the memory bus is immune to cache-side changes during
  // the transaction; it is cleared on the edge that returns to IDLE.
  // ---------------------------------------------------------------------
  always_comb begin
    streak_d = streak_q;
    read_d   = read_q;
    write_d  = write_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    if (state_q == IDLE) begin
      if (win_d) begin
        // Write takes precedence if both strobes are set.
        write_d  = D_mem_write;
        read_d   = D_mem_read & ~D_mem_write;
        addr_d   = D_mem_addr;
        wdata_d  = D_mem_wdata;
        streak_d = req_i ? sat_inc(streak_q) : '0;
      end else if (win_i) begin
        write_d  = I_mem_write;
        read_d   = I_mem_read & ~I_mem_write;
        addr_d   = I_mem_addr;
        wdata_d  = I_mem_wdata;
        streak_d = '0;
      end
    end else if (mem_ready) begin
      read_d  = 1'b0;
      write_d = 1'b0;
      addr_d  = '0;
      wdata_d = '0;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: outputs. Completion is routed combinationally to the owner; a
  // mem_ready while IDLE reaches neither cache.
  // ---------------------------------------------------------------------
  always_comb begin
    I_mem_ready = mem_ready & (state_q == GRANT_I);
    D_mem_ready = mem_ready & (state_q == GRANT_D);
  end

  assign I_mem_rdata = mem_rdata;
  assign D_mem_rdata = mem_rdata;

  assign mem_read  = read_q;
  assign mem_write = write_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Randomized bench: two cache agents and a memory agent drive the arbiter
//   while a transaction-level reference model predicts the memory bus and
//   completion outputs every cycle.
//   Phase 0: I-cache only. Phase 1: both caches request continuously
//   (starvation limit). Phase 2: mixed traffic with dropped requests,
//   spurious mem_ready and occasional resets.
module tb_mem_arbiter;

  localparam int AW   = 28;
  localparam int DW   = 128;
  localparam int SMAX = 4;
  localparam int N_CYC = 3000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          I_mem_read = 1'b0, I_mem_write = 1'b0;
  logic [AW-1:0] I_mem_addr = '0;
  logic [DW-1:0] I_mem_wdata = '0;
  logic [DW-1:0] I_mem_rdata;
  logic          I_mem_ready;
  logic          D_mem_read = 1'b0, D_mem_write = 1'b0;
  logic [AW-1:0] D_mem_addr = '0;
  logic [DW-1:0] D_mem_wdata = '0;
  logic [DW-1:0] D_mem_rdata;
  logic          D_mem_ready;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .D_STREAK_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .I_mem_read(I_mem_read), .I_mem_write(I_mem_write),
    .I_mem_addr(I_mem_addr), .I_mem_wdata(I_mem_wdata),
    .I_mem_rdata(I_mem_rdata), .I_mem_ready(I_mem_ready),
    .D_mem_read(D_mem_read), .D_mem_write(D_mem_write),
    .D_mem_addr(D_mem_addr), .D_mem_wdata(D_mem_wdata),
    .D_mem_rdata(D_mem_rdata), .D_mem_ready(D_mem_ready),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Cache agent state: one outstanding request each.
  bit            i_pend = 0, d_pend = 0;
  bit            i_rd, i_wr, d_rd, d_wr;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] i_wdata, d_wdata;

  // Reference model: who owns the bus (0 none, 1 I, 2 D), how many D
  // grants in a row were taken while I waited, and the command on the bus.
  int            owner = 0;
  int            streak = 0;
  int            lat = 0;
  int            n_i_grant = 0, n_d_grant = 0;
  bit            m_rd = 0, m_wr = 0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;

  function automatic logic [DW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    int phase, p_i, p_d;
    bit req_i, req_d, give_i;
    int unsigned op;

    repeat (3) @(posedge clk);

    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      phase = (cyc < 200) ? 0 : (cyc < 600) ? 1 : 2;
      p_i   = (phase == 0) ? 30 : (phase == 1) ? 100 : 40;
      p_d   = (phase == 0) ? 0  : (phase == 1) ? 100 : 50;

      @(negedge clk);
      rst_n = !(phase == 2 && $urandom_range(0, 79) == 0);

      // New requests; the I-cache only writes in the mixed phase.
      if (!i_pend && $urandom_range(0, 99) < p_i) begin
        i_pend = 1;
        op = (phase == 2) ? $urandom_range(1, 3) : 1;
        i_rd = op[0]; i_wr = op[1];
        i_addr = AW'($urandom); i_wdata = rand_line();
      end
      if (!d_pend && $urandom_range(0, 99) < p_d) begin
        d_pend = 1;
        op = $urandom_range(1, 3);
        d_rd = op[0]; d_wr = op[1];
        d_addr = AW'($urandom); d_wdata = rand_line();
      end

      // Mid-grant: owner drops its request and scrambles its inputs.
      if (phase == 2 && owner == 1 && i_pend && $urandom_range(0, 19) == 0) begin
        i_pend = 0; i_addr = AW'($urandom); i_wdata = rand_line();
      end
      if (phase == 2 && owner == 2 && d_pend && $urandom_range(0, 19) == 0) begin
        d_pend = 0; d_addr = AW'($urandom); d_wdata = rand_line();
      end

      I_mem_read  = i_pend & i_rd;  I_mem_write = i_pend & i_wr;
      I_mem_addr  = i_addr;         I_mem_wdata = i_wdata;
      D_mem_read  = d_pend & d_rd;  D_mem_write = d_pend & d_wr;
      D_mem_addr  = d_addr;         D_mem_wdata = d_wdata;

      // Memory agent: completes after the drawn latency; occasional
      // spurious pulse while idle; quiet during reset.
      if (!rst_n) mem_ready = 1'b0;
      else if (owner != 0) begin
        if (lat == 0) mem_ready = 1'b1;
        else begin mem_ready = 1'b0; lat--; end
      end else mem_ready = (phase == 2 && $urandom_range(0, 9) == 0);
      mem_rdata = rand_line();

      #1;
      check("mem_read",  DW'(mem_read),  DW'(m_rd));
      check("mem_write", DW'(mem_write), DW'(m_wr));
      check("mem_addr",  DW'(mem_addr),  DW'(m_addr));
      check("mem_wdata", mem_wdata, m_wdata);
      check("I_ready", DW'(I_mem_ready), DW'(mem_ready && owner == 1));
      check("D_ready", DW'(D_mem_ready), DW'(mem_ready && owner == 2));
      check("I_rdata", I_mem_rdata, mem_rdata);
      check("D_rdata", D_mem_rdata, mem_rdata);
      check("rw_excl", DW'(mem_read & mem_write), '0);

      // Advance the model to the coming edge.
      req_i = I_mem_read | I_mem_write;
      req_d = D_mem_read | D_mem_write;
      if (!rst_n) begin
        owner = 0; streak = 0;
        m_rd = 0; m_wr = 0; m_addr = '0; m_wdata = '0;
        i_pend = 0; d_pend = 0;
      end else if (owner != 0) begin
        if (mem_ready) begin
          if (owner == 1) i_pend = 0; else d_pend = 0;
          owner = 0;
          m_rd = 0; m_wr = 0; m_addr = '0; m_wdata = '0;
        end
      end else if (req_i || req_d) begin
        // I is served when D is absent or D has had its quota of turns
        // while I was waiting.
        give_i = req_i && (!req_d || streak == SMAX);
        if (give_i) begin
          owner = 1; streak = 0; n_i_grant++;
          m_wr = I_mem_write; m_rd = I_mem_read && !I_mem_write;
          m_addr = I_mem_addr; m_wdata = I_mem_wdata;
        end else begin
          owner = 2; n_d_grant++;
          streak = req_i ? ((streak < 15) ? streak + 1 : 15) : 0;
          m_wr = D_mem_write; m_rd = D_mem_read && !D_mem_write;
          m_addr = D_mem_addr; m_wdata = D_mem_wdata;
        end
        lat = $urandom_range(0, 4);
      end

      if (cyc < 40 || (cyc % 100) == 0)
        $display("cyc %0d owner=%0d streak=%0d rd=%0b wr=%0b addr=%h I_rdy=%0b D_rdy=%0b",
                 cyc, owner, streak, mem_read, mem_write, mem_addr, I_mem_ready, D_mem_ready);
    end

    $display("grants: I=%0d D=%0d", n_i_grant, n_d_grant);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
